pfc_bpred: RTL and testbench
============================

Name: pfc_bpred

Overview:
- Parametrised next-generation program flow control unit for the RV32 core.
- Owns the fetch PC register and predicts the next fetch PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves branches and jumps at execute with the existing 6-bit control encoding, flags mispredicts, redirects fetch and trains the BTB.
- Sits between the fetch stage and the execute-stage operand path.

Parameters:
- XLEN, 32, datapath and PC width.
- BTB_ENTRIES, 16, number of BTB entries; must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC value after reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- stall  input  1  holds the fetch PC.
- fetch_pc  output  XLEN  current fetch PC.
- pred_taken  output  1  prediction for fetch_pc; combinational.
- pred_next  output  XLEN  predicted next PC; combinational.
- ex_valid  input  1  the execute-stage instruction is valid.
- ex_pc  input  XLEN  PC of the execute-stage instruction.
- ex_pred_taken  input  1  prediction carried down the pipeline with the instruction.
- ex_pred_target  input  XLEN  predicted target carried down the pipeline with the instruction.
- immediate  input  XLEN  sign-extended immediate.
- rs1  input  XLEN  register operand 1.
- rs2  input  XLEN  register operand 2.
- control_signals  input  6  bit [5] Rs1_Sel, [4] PL, [3] JB, [2:0] BC.
- actual_taken  output  1  resolved taken/not-taken.
- pcnew  output  XLEN  resolved target.
- link_pc  output  XLEN  ex_pc+4.
- redirect  output  1  mispredict: fetch must restart.
- redirect_pc  output  XLEN  correct next PC.
- branch_count  output  CNT_W  resolved control-flow instructions.
- mispredict_count  output  CNT_W  number of redirects.

Behaviour:
- Reset (async, on rst high):
  - fetch_pc = RESET_PC.
  - All BTB valid bits = 0, counters = 2'b01.
  - Both performance counters = 0.
  - redirect = 0 while rst is high.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target, ctr[1:0], is_jump.
  - IDX = log2(BTB_ENTRIES); index = pc[IDX+1:2].
- Prediction (combinational on fetch_pc):
  - hit = valid && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_next = pred_taken ? target : fetch_pc+4.
- Resolution (combinational, qualified by ex_valid):
  - JALR = PL & JB & ~Rs1_Sel.
  - Condition by BC: 000 BEQ, 001 BNE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. BC values 010 and 011 give condition 0.
  - actual_taken = PL & (JB | condition).
  - pcnew = (JALR ? rs1 : ex_pc) + immediate, modulo 2^XLEN. For JALR, bit 0 is forced to 0.
- Mispredict:
  - redirect = ex_valid & ((actual_taken != ex_pred_taken) | (actual_taken & ex_pred_taken & pcnew != ex_pred_target)).
  - redirect_pc = actual_taken ? pcnew : link_pc.
- fetch_pc update on each rising edge:
  - redirect → redirect_pc; redirect has priority over stall.
  - else if !stall → pred_next.
  - else hold.
- BTB training (clocked, ex_valid only, entry at index(ex_pc)):
  - PL=1, miss: allocate. valid=1, tag, target=pcnew, is_jump=JB, ctr = JB ? 11 : (actual_taken ? 10 : 01).
  - PL=1, hit: ctr increments (taken) or decrements (not taken), saturating at 11/00. Target is overwritten with pcnew when taken. is_jump=JB.
  - PL=0 with hit: clear valid (alias cleanup). A misprediction on such an instruction also causes a redirect to ex_pc+4.
- Read-during-write: fetch prediction sees pre-update BTB contents; an update is visible on the next cycle.
- Counters:
  - branch_count increments on ex_valid & PL.
  - mispredict_count increments on redirect.
  - Both saturate at all-ones; no wrap.
- No stall gating on resolution: the execute stage guarantees ex_valid=0 during bubbles.

Test Plan:
- Reset: assert rst mid-run → fetch_pc=0x0 immediately. Release with stall=0 → fetch_pc 0x0, 0x4, 0x8, and all counters are 0.
- BEQ resolution and training:
  - Stimulus: ex_pc=0x40, imm=0x20, rs1=rs2=5, ctrl=6'b010000, ex_pred_taken=0.
  - Response: redirect=1, redirect_pc=0x60, fetch_pc=0x60 next cycle.
  - Later, fetch_pc=0x40 → pred_next=0x60, pred_taken=1.
- JALR target alignment:
  - Stimulus: rs1=0x1001, imm=4, ctrl=6'b011000, ex_pc=0x200, ex_pred_taken=0.
  - Response: pcnew=0x1004, link_pc=0x204, redirect=1.
- Counter hysteresis:
  - Four taken BLT at 0x80 (ctrl=6'b010100) → ctr=11.
  - One not-taken → ctr=10, still predicts taken.
  - Second not-taken → ctr=01, pred_next=0x84.
- Stall and redirect priority:
  - stall=1 with redirect=1 → fetch_pc takes redirect_pc.
  - stall=1 alone → fetch_pc holds for 3 cycles.
- Aliasing and reserved BC:
  - Entry trained at 0x40; fetch 0x440 (same index, different tag) → pred_next=0x444.
  - BC=010 with PL=1, JB=0 → actual_taken=0.
  - PL=0 at a hit index → entry invalidated.

Source files
------------

// File: rtl/pfc_bpred_if.sv
`default_nettype none
// ============================================================================
// Module      : pfc_bpred_if
// Description : Fetch-side and execute-side bus of the program flow control
//               unit (prediction, resolution, redirect, statistics).
// Revision    : 1.0 - initial release
// ============================================================================
interface pfc_bpred_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Fetch side
    logic             stall;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_next;

    // Execute side
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic [XLEN-1:0]  immediate;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [5:0]       control_signals;
    logic             actual_taken;
    logic [XLEN-1:0]  pcnew;
    logic [XLEN-1:0]  link_pc;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;

    // Statistics
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output stall, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
               immediate, rs1, rs2, control_signals,
        input  fetch_pc, pred_taken, pred_next, actual_taken, pcnew, link_pc,
               redirect, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  stall, ex_valid, ex_pc, ex_pred_taken, ex_pred_target,
               immediate, rs1, rs2, control_signals,
        output fetch_pc, pred_taken, pred_next, actual_taken, pcnew, link_pc,
               redirect, redirect_pc, branch_count, mispredict_count
    );
endinterface
`default_nettype wire

// File: rtl/pfc_bpred.sv
`default_nettype none
// ============================================================================
// Module      : pfc_bpred
// Description : Fetch PC owner with direct-mapped BTB prediction, execute-stage
//               branch resolution, mispredict redirect and BTB training.
// Revision    : 1.0 - initial release
// ============================================================================
module pfc_bpred #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              CNT_W       = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pfc_bpred_if.slave bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [BTB_ENTRIES-1:0] r_btb_jump;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr    [BTB_ENTRIES];

    logic [XLEN-1:0]  r_fetch_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX-1:0]   w_f_idx;
    logic             w_f_hit;
    logic             w_pred_taken;
    logic [IDX-1:0]   w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;

    logic             w_rs1_sel;
    logic             w_pl;
    logic             w_jb;
    logic [2:0]       w_bc;
    logic             w_jalr;
    logic             w_cond;
    logic             w_actual;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_pcnew;
    logic [XLEN-1:0]  w_link;
    logic             w_redirect;
    logic [XLEN-1:0]  w_redirect_pc;

    // ---------------- Prediction (reads pre-update BTB contents) ----------
    assign w_f_idx      = r_fetch_pc[IDX+1:2];
    assign w_f_hit      = r_btb_valid[w_f_idx] &&
                          (r_btb_tag[w_f_idx] == r_fetch_pc[XLEN-1:IDX+2]);
    assign w_pred_taken = w_f_hit && (r_btb_jump[w_f_idx] || r_btb_ctr[w_f_idx][1]);

    assign bus.fetch_pc   = r_fetch_pc;
    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_next  = w_pred_taken ? r_btb_target[w_f_idx] : r_fetch_pc + c_pc_step;

    // ---------------- Resolution ------------------------------------------
    assign w_rs1_sel = bus.control_signals[5];
    assign w_pl      = bus.control_signals[4];
    assign w_jb      = bus.control_signals[3];
    assign w_bc      = bus.control_signals[2:0];
    assign w_jalr    = w_pl & w_jb & ~w_rs1_sel;

    always_comb begin
        w_cond = 1'b0;
        case (w_bc)
            3'b000:  w_cond = (bus.rs1 == bus.rs2);
            3'b001:  w_cond = (bus.rs1 != bus.rs2);
            3'b100:  w_cond = ($signed(bus.rs1) <  $signed(bus.rs2));
            3'b101:  w_cond = ($signed(bus.rs1) >= $signed(bus.rs2));
            3'b110:  w_cond = (bus.rs1 <  bus.rs2);
            3'b111:  w_cond = (bus.rs1 >= bus.rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_actual = w_pl & (w_jb | w_cond);
    assign w_sum    = (w_jalr ? bus.rs1 : bus.ex_pc) + bus.immediate;
    assign w_pcnew  = {w_sum[XLEN-1:1], w_sum[0] & ~w_jalr};
    assign w_link   = bus.ex_pc + c_pc_step;

    // A correct direction with a stale target still needs a restart.
    assign w_redirect = ~rst & bus.ex_valid &
                        ((w_actual != bus.ex_pred_taken) |
                         (w_actual & bus.ex_pred_taken & (w_pcnew != bus.ex_pred_target)));
    assign w_redirect_pc = w_actual ? w_pcnew : w_link;

    assign bus.actual_taken = bus.ex_valid & w_actual;
    assign bus.pcnew        = w_pcnew;
    assign bus.link_pc      = w_link;
    assign bus.redirect     = w_redirect;
    assign bus.redirect_pc  = w_redirect_pc;

    // ---------------- Fetch PC --------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (!bus.stall) begin
            r_fetch_pc <= bus.pred_next;
        end
    end

    // ---------------- BTB training ----------------------------------------
    assign w_ex_idx = bus.ex_pc[IDX+1:2];
    assign w_ex_tag = bus.ex_pc[XLEN-1:IDX+2];
    assign w_ex_hit = r_btb_valid[w_ex_idx] && (r_btb_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btb_valid <= '0;
            r_btb_jump  <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
                r_btb_ctr[i]    <= 2'b01;
            end
        end else if (bus.ex_valid) begin
            if (w_pl) begin
                r_btb_jump[w_ex_idx] <= w_jb;
                if (w_ex_hit) begin
                    if (w_actual) begin
                        r_btb_target[w_ex_idx] <= w_pcnew;
                        if (r_btb_ctr[w_ex_idx] != 2'b11)
                            r_btb_ctr[w_ex_idx] <= r_btb_ctr[w_ex_idx] + 2'd1;
                    end else if (r_btb_ctr[w_ex_idx] != 2'b00) begin
                        r_btb_ctr[w_ex_idx] <= r_btb_ctr[w_ex_idx] - 2'd1;
                    end
                end else begin
                    r_btb_valid[w_ex_idx]  <= 1'b1;
                    r_btb_tag[w_ex_idx]    <= w_ex_tag;
                    r_btb_target[w_ex_idx] <= w_pcnew;
                    r_btb_ctr[w_ex_idx]    <= w_jb ? 2'b11 : (w_actual ? 2'b10 : 2'b01);
                end
            end else if (w_ex_hit) begin
                // A non-control instruction aliased onto this entry: drop it.
                r_btb_valid[w_ex_idx] <= 1'b0;
            end
        end
    end

    // ---------------- Saturating statistics -------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (bus.ex_valid && w_pl && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_redirect && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign bus.branch_count     = r_branch_cnt;
    assign bus.mispredict_count = r_mispred_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pfc_bpred.sv
`default_nettype none
// ============================================================================
// Module      : tb_pfc_bpred
// Description : Self-checking bench for pfc_bpred: resolution vector table
//               plus directed prediction/training/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pfc_bpred;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pfc_bpred_if #(.XLEN(32), .CNT_W(16)) bus ();

    pfc_bpred #(
        .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0000_0000), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mis = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_pcnew;
        logic [31:0] e_link;
        logic        e_red;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] ctrl, input logic pt,
                            input logic [31:0] ptgt);
        bus.ex_pc           = pc;
        bus.immediate       = imm;
        bus.rs1             = a;
        bus.rs2             = b;
        bus.control_signals = ctrl;
        bus.ex_pred_taken   = pt;
        bus.ex_pred_target  = ptgt;
        bus.ex_valid        = 1'b1;
    endtask

    // One clocked execute-stage instruction, with stall held high.
    task automatic ex_cycle(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] ctrl, input logic pt,
                            input logic [31:0] ptgt, input logic e_red,
                            input logic [31:0] e_rpc);
        drive_ex(pc, imm, a, b, ctrl, pt, ptgt);
        #1;
        check($sformatf("redirect@%0h", pc), {31'b0, bus.redirect}, {31'b0, e_red});
        if (e_red) check($sformatf("redirect_pc@%0h", pc), bus.redirect_pc, e_rpc);
        if (ctrl[4]) exp_br++;
        if (e_red) exp_mis++;
        cyc();
        bus.ex_valid = 1'b0;
        if (e_red) check($sformatf("fetch_after_redirect@%0h", pc), bus.fetch_pc, e_rpc);
    endtask

    task automatic goto_pc(input logic [31:0] t);
        ex_cycle(32'hF04, 32'h0, t, 32'h0, 6'b011000, 1'b0, 32'h0, 1'b1, t);
    endtask

    task automatic check_pred(input string name, input logic e_taken, input logic [31:0] e_next);
        #1;
        check({name, "_taken"}, {31'b0, bus.pred_taken}, {31'b0, e_taken});
        check({name, "_next"}, bus.pred_next, e_next);
    endtask

    task automatic check_counts(input string name);
        check({name, "_branch_count"}, {16'b0, bus.branch_count}, exp_br);
        check({name, "_mispredict_count"}, {16'b0, bus.mispredict_count}, exp_mis);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //            pc          imm          rs1          rs2       ctrl       pt ptgt        taken pcnew       link         red rpc
        vecs[0]  = '{32'h40,     32'h20,      32'h5,       32'h5,    6'b010000, 0, 32'h0,      1, 32'h60,     32'h44,      1, 32'h60};
        vecs[1]  = '{32'h40,     32'h20,      32'h5,       32'h6,    6'b010000, 0, 32'h0,      0, 32'h60,     32'h44,      0, 32'h44};
        vecs[2]  = '{32'h40,     32'h20,      32'h5,       32'h6,    6'b010001, 1, 32'h60,     1, 32'h60,     32'h44,      0, 32'h60};
        vecs[3]  = '{32'h40,     32'h20,      32'h5,       32'h6,    6'b010001, 1, 32'h64,     1, 32'h60,     32'h44,      1, 32'h60};
        vecs[4]  = '{32'h80,     32'hFFFFFFF0,32'hFFFFFFFF,32'h1,    6'b010100, 0, 32'h0,      1, 32'h70,     32'h84,      1, 32'h70};
        vecs[5]  = '{32'h80,     32'hFFFFFFF0,32'hFFFFFFFF,32'h1,    6'b010101, 1, 32'h70,     0, 32'h70,     32'h84,      1, 32'h84};
        vecs[6]  = '{32'h80,     32'hFFFFFFF0,32'hFFFFFFFF,32'h1,    6'b010110, 0, 32'h0,      0, 32'h70,     32'h84,      0, 32'h84};
        vecs[7]  = '{32'h80,     32'hFFFFFFF0,32'hFFFFFFFF,32'h1,    6'b010111, 1, 32'h70,     1, 32'h70,     32'h84,      0, 32'h70};
        vecs[8]  = '{32'h100,    32'h10,      32'h0,       32'h0,    6'b111000, 1, 32'h110,    1, 32'h110,    32'h104,     0, 32'h110};
        vecs[9]  = '{32'h200,    32'h4,       32'h1001,    32'h0,    6'b011000, 0, 32'h0,      1, 32'h1004,   32'h204,     1, 32'h1004};
        vecs[10] = '{32'h40,     32'h20,      32'h5,       32'h5,    6'b010010, 0, 32'h0,      0, 32'h60,     32'h44,      0, 32'h44};
        vecs[11] = '{32'h300,    32'h8,       32'h0,       32'h0,    6'b000000, 1, 32'h308,    0, 32'h308,    32'h304,     1, 32'h304};
        vecs[12] = '{32'hFFFFFFFC,32'h8,      32'h0,       32'h0,    6'b111000, 0, 32'h0,      1, 32'h4,      32'h0,       1, 32'h4};

        rst = 1'b1;
        bus.stall = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_pc = '0; bus.immediate = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.control_signals = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
        cyc();
        cyc();

        // Reset state, including redirect suppressed during reset
        check("reset_fetch_pc", bus.fetch_pc, 32'h0);
        check_counts("reset");
        drive_ex(32'h40, 32'h20, 32'h5, 32'h5, 6'b010000, 1'b0, 32'h0);
        #1;
        check("reset_redirect", {31'b0, bus.redirect}, 32'h0);
        bus.ex_valid = 1'b0;

        // Release and free-run
        rst = 1'b0;
        bus.stall = 1'b0;
        #1;
        check("run_pc0", bus.fetch_pc, 32'h0);
        cyc();
        check("run_pc4", bus.fetch_pc, 32'h4);
        cyc();
        check("run_pc8", bus.fetch_pc, 32'h8);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("stall_hold%0d", i), bus.fetch_pc, 32'h8);
        end

        // Combinational resolution table (ex_valid dropped before each edge)
        for (int i = 0; i < 13; i++) begin
            drive_ex(vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].b,
                     vecs[i].ctrl, vecs[i].pt, vecs[i].ptgt);
            #1;
            check($sformatf("v%0d_taken", i), {31'b0, bus.actual_taken}, {31'b0, vecs[i].e_taken});
            check($sformatf("v%0d_pcnew", i), bus.pcnew, vecs[i].e_pcnew);
            check($sformatf("v%0d_link", i), bus.link_pc, vecs[i].e_link);
            check($sformatf("v%0d_redirect", i), {31'b0, bus.redirect}, {31'b0, vecs[i].e_red});
            check($sformatf("v%0d_rpc", i), bus.redirect_pc, vecs[i].e_rpc);
            bus.ex_valid = 1'b0;
            cyc();
        end
        check("table_no_training", bus.fetch_pc, 32'h8);
        check_counts("table");

        // BEQ train at 0x40, then predict from it; alias 0x440 must miss
        ex_cycle(32'h40, 32'h20, 32'h5, 32'h5, 6'b010000, 1'b0, 32'h0, 1'b1, 32'h60);
        goto_pc(32'h40);
        check_pred("beq_trained", 1'b1, 32'h60);
        goto_pc(32'h440);
        check_pred("alias_440", 1'b0, 32'h444);

        // Non-control instruction at a hit index: redirect and invalidate
        ex_cycle(32'h40, 32'h20, 32'h0, 32'h0, 6'b000000, 1'b1, 32'h60, 1'b1, 32'h44);
        goto_pc(32'h40);
        check_pred("invalidated_40", 1'b0, 32'h44);

        // Counter hysteresis on BLT at 0x80
        for (int i = 0; i < 4; i++)
            ex_cycle(32'h80, 32'h10, 32'h1, 32'h2, 6'b010100, 1'b1, 32'h90, 1'b0, 32'h0);
        goto_pc(32'h80);
        check_pred("blt_ctr11", 1'b1, 32'h90);
        ex_cycle(32'h80, 32'h10, 32'h2, 32'h1, 6'b010100, 1'b1, 32'h90, 1'b1, 32'h84);
        goto_pc(32'h80);
        check_pred("blt_ctr10", 1'b1, 32'h90);
        ex_cycle(32'h80, 32'h10, 32'h2, 32'h1, 6'b010100, 1'b1, 32'h90, 1'b1, 32'h84);
        goto_pc(32'h80);
        check_pred("blt_ctr01", 1'b0, 32'h84);
        check_counts("after_training");

        // Mid-run asynchronous reset
        rst = 1'b1;
        #1;
        check("midrst_fetch_pc", bus.fetch_pc, 32'h0);
        check("midrst_branch_count", {16'b0, bus.branch_count}, 32'h0);
        check("midrst_mispredict_count", {16'b0, bus.mispredict_count}, 32'h0);
        drive_ex(32'h40, 32'h20, 32'h5, 32'h5, 6'b010000, 1'b0, 32'h0);
        #1;
        check("midrst_redirect", {31'b0, bus.redirect}, 32'h0);
        bus.ex_valid = 1'b0;
        cyc();
        rst = 1'b0;
        exp_br = 0;
        exp_mis = 0;
        goto_pc(32'h80);
        check_pred("btb_cleared_80", 1'b0, 32'h84);
        check_counts("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
